demux1x4_buf: RTL
=================

# demux1x4_buf

Registered 1-to-4 demultiplexer with valid/ready handshaking, the inverse of the 4-to-1 select mux. It steers one producer's data word to one of four consumer lanes chosen by a 2-bit select. Each lane has a 2-entry buffer, so the block sustains one transfer per cycle and isolates consumer stalls from the producer's timing path. It sits between a shared result source (e.g. the writeback bus) and up to four destination units.

## Interface
- WIDTH, 32, data word width in bits
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  producer has a word this cycle
- in_ready  output  1  selected lane can accept this cycle
- in_data  input  WIDTH  word to steer
- in_slct  input  2  destination lane: 0→lane 00, 1→lane 01, 2→lane 10, 3→lane 11
- out_valid  output  4  bit k: lane k head entry valid
- out_ready  input  4  bit k: consumer k takes head this cycle
- out_data_00 / out_data_01 / out_data_10 / out_data_11  output  WIDTH each  head entry of each lane

## Operation
- Input transfer when in_valid && in_ready; word appended to lane in_slct.
- Output transfer on lane k when out_valid[k] && out_ready[k]; head popped.
- Each lane: 2-entry FIFO, 2-bit occupancy count (0..2), 1-bit read and write pointers wrapping 1→0.
- in_ready = (count[in_slct] != 2). It depends only on registered count and in_slct; there is no combinational path from out_ready to in_ready.
- in_ready is meaningful even when in_valid is low. in_slct and in_data are ignored when in_valid is low.
- out_valid[k] = (count[k] != 0). out_data_k is storage at the lane's read pointer.
- Simultaneous push and pop on the same lane:
  - count 1: count stays 1; the old head leaves and the new word becomes head next cycle.
  - count 2: push is blocked because in_ready is low; the pop proceeds and count becomes 1.
- Push to one lane and pops on other lanes in the same cycle are independent.
- Per-lane FIFO order is preserved. There is no ordering guarantee across lanes.
- Input is never dropped or duplicated. Pushing when full is impossible by construction.
- Entry storage is not cleared on pop. out_data_k is don't-care while out_valid[k] = 0.

## Timing
- Latency: word accepted at edge N is visible on out_valid/out_data of its lane after edge N (in cycle N+1). Pass-through is one cycle with no combinational bypass.
- Throughput: one input transfer per cycle when the target lane is not full. A lane popped every cycle never fills.
- Reset (rst_n low, asynchronous, at any time including mid-transfer):
  - all counts and pointers 0; out_valid = 4'b0000; in_ready = 1; out_data_* = 0.
  - All buffered words are discarded.
- Deassertion: the first transfer can be accepted on the first rising edge with rst_n high.

## Structure
- Lane select encodings (SLCT_00..SLCT_11 = 0..3) and the lane count (4) belong in the shared define file alongside the mux select constants.
- One natural sub-module: demux_lane_buf, a WIDTH-parameterised 2-entry FIFO.
  - Ports: clk, rst_n, push, push_data, pop, full, valid, head_data.
  - Instantiated four times.
- The top level decodes in_slct into a one-hot push vector gated by in_valid && in_ready.

## Test plan
- Reset then idle, WIDTH=4 → out_valid=0000, in_ready=1, all out_data=0.
- Push 2,4,6,8 with slct 0,1,2,3 on consecutive cycles, all out_ready=1 → each lane shows its word one cycle after acceptance (e.g. out_data_10=0110 with out_valid=0100); no stall.
- out_ready[1]=0; push 3,5,7 to lane 1 → first two accepted; in_ready=0 on the third. Raise out_ready[1] → 3 then 5 drain in order, then 7 accepted.
- Lane 2 at count 1 with simultaneous push 9 and pop → count stays 1; next head is 9.
- Lane 0 full with in_slct=0 and in_valid=1, out_ready[0]=1 → in_ready stays 0 in that cycle (no out_ready→in_ready path); the word is accepted the following cycle.
- Assert rst_n low asynchronously between edges with lanes partially full → out_valid=0000 immediately; after release, no stale words appear.

Source files
------------

// File: rtl/demux1x4_buf_pkg.sv
// Shared definitions for the 1-to-4 buffered demultiplexer: lane select
// encodings, lane count and the select-to-one-hot decode helper.
package demux1x4_buf_pkg;

    // Lane select encodings; they match the 4-to-1 select mux.
    typedef enum logic [1:0] {
        SLCT_00 = 2'd0,
        SLCT_01 = 2'd1,
        SLCT_10 = 2'd2,
        SLCT_11 = 2'd3
    } slct_e;

    localparam int NUM_LANES = 4;
    localparam int LANE_DEPTH = 2;

    // Decode a 2-bit lane select into a one-hot lane vector.
    function automatic logic [NUM_LANES-1:0] slct_onehot(input logic [1:0] slct);
        logic [NUM_LANES-1:0] v;
        v = '0;
        v[slct] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux1x4_buf_lane_buf.sv
// Two-entry FIFO holding the words queued for one demux output lane.
// The head entry is presented directly from storage (registered output).
module demux_lane_buf
    import demux1x4_buf_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] r_mem [LANE_DEPTH];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic             w_push_ok;
    logic             w_pop_ok;

    // Guard against overflow/underflow locally so the lane is safe on its own.
    assign w_push_ok = push && (r_count != 2'd2);
    assign w_pop_ok  = pop  && (r_count != 2'd0);

    // Storage and pointers; storage is cleared on reset so heads read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wptr] <= push_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop_ok) begin
                r_rptr <= ~r_rptr;
            end
        end
    end

    // Occupancy: push+pop together leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
        end else begin
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign full      = (r_count == 2'd2);
    assign valid     = (r_count != 2'd0);
    assign head_data = r_mem[r_rptr];

endmodule

// File: rtl/demux1x4_buf.sv
// Registered 1-to-4 demultiplexer with valid/ready handshaking. One producer
// word is steered to the lane chosen by in_slct; each lane buffers two words
// so consumer stalls never reach the producer combinationally.
module demux1x4_buf
    import demux1x4_buf_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_slct,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data_00,
    output logic [WIDTH-1:0] out_data_01,
    output logic [WIDTH-1:0] out_data_10,
    output logic [WIDTH-1:0] out_data_11
);

    logic [NUM_LANES-1:0] w_full;
    logic [NUM_LANES-1:0] w_push;
    logic [NUM_LANES-1:0] w_pop;
    logic [WIDTH-1:0]     w_head [NUM_LANES];

    // Readiness comes only from registered lane occupancy, never from out_ready.
    assign in_ready = ~w_full[in_slct];

    // One-hot push toward the selected lane, only on an accepted transfer.
    always_comb begin
        w_push = '0;
        if (in_valid && in_ready) begin
            w_push = slct_onehot(in_slct);
        end
    end

    assign w_pop = out_valid & out_ready;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        demux_lane_buf #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (w_push[g]),
            .push_data (in_data),
            .pop       (w_pop[g]),
            .full      (w_full[g]),
            .valid     (out_valid[g]),
            .head_data (w_head[g])
        );
    end

    assign out_data_00 = w_head[SLCT_00];
    assign out_data_01 = w_head[SLCT_01];
    assign out_data_10 = w_head[SLCT_10];
    assign out_data_11 = w_head[SLCT_11];

endmodule
